// File: rtl/image_loader_pkg.sv
// ----------------------------------------------------------------------------
// image_loader_pkg
//   Shared definitions for the image loader: state encoding, default frame
//   geometry, checksum/timeout counter widths and a counter-width helper.
//   Also usable by the SAD control unit and the bench.
// ----------------------------------------------------------------------------
package image_loader_pkg;

   localparam int unsigned IMG_ROWS_DEF    = 480;
   localparam int unsigned IMG_COLS_DEF    = 40;
   localparam int unsigned PIX_W_DEF       = 8;
   localparam int unsigned ROW_AW_DEF      = 9;
   localparam int unsigned TIMEOUT_CYC_DEF = 100000;

   localparam int unsigned CHK_W = 16;
   localparam int unsigned TMO_W = 17;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_DONE,
      ST_ERROR
   } load_state_t;

   // Width of a counter spanning 0..n-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/image_loader_row_packer.sv
// ----------------------------------------------------------------------------
// image_loader_row_packer
//   Packs IMG_COLS consecutive pixel bytes into one row word. The first byte
//   of a row ends up in the least-significant pixel slot.
// Ports
//   clock     in   system clock, rising edge
//   reset     in   asynchronous, active-low
//   clear     in   restart a row: column counter and shift register to 0
//   shift_en  in   accept rx_data this cycle
//   rx_data   in   pixel byte
//   last_col  out  column counter is at IMG_COLS-1 (combinational)
//   row_we    out  registered 1-cycle strobe, row_data holds a complete row
//   row_data  out  registered packed row, holds between strobes
// ----------------------------------------------------------------------------
module image_loader_row_packer
   import image_loader_pkg::*;
#(
   parameter int unsigned IMG_COLS = IMG_COLS_DEF,
   parameter int unsigned PIX_W    = PIX_W_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      shift_en,
   input  logic [PIX_W-1:0]          rx_data,
   output logic                      last_col,
   output logic                      row_we,
   output logic [IMG_COLS*PIX_W-1:0] row_data
);

   localparam int unsigned COL_W    = cnt_width(IMG_COLS);
   localparam int unsigned ROW_BITS = IMG_COLS * PIX_W;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - 1);

   logic [COL_W-1:0]    col;
   logic [ROW_BITS-1:0] shift_reg;
   logic [ROW_BITS-1:0] shift_next;

   always_comb begin
      shift_next = {rx_data, shift_reg[ROW_BITS-1:PIX_W]};
   end

   assign last_col = (col == COL_LAST);

   // row_data is a separate register from shift_reg, so the next row's first
   // byte can be shifted in on the cycle right after the row completes.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col       <= '0;
         shift_reg <= '0;
         row_data  <= '0;
         row_we    <= 1'b0;
      end else begin
         row_we <= 1'b0;
         if (clear) begin
            col       <= '0;
            shift_reg <= '0;
         end else if (shift_en) begin
            shift_reg <= shift_next;
            if (last_col) begin
               col      <= '0;
               row_data <= shift_next;
               row_we   <= 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/image_loader.sv
// ----------------------------------------------------------------------------
// image_loader
//   Receives a frame as a UART byte stream, packs IMG_COLS pixels per row and
//   writes rows 0..IMG_ROWS-1 to the image RAM in order. frameReady goes high
//   once the last row is committed. Keeps a 16-bit byte checksum and raises
//   loadError if the stream stalls for TIMEOUT_CYC cycles while loading.
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low; clears all state
//   start       in   begin/restart a frame load (level)
//   rxValid     in   1-cycle strobe, rxData holds a new byte
//   rxData      in   received pixel byte
//   ramWe       out  image-RAM write enable, 1-cycle pulse per row
//   ramAddr     out  row address for ramWe
//   ramData     out  packed row, column c at [c*PIX_W +: PIX_W]
//   busy        out  high while loading or flushing the last row
//   frameReady  out  high once the full frame is written
//   loadError   out  high after an inter-byte timeout
//   checksum    out  sum of accepted bytes mod 2^16
// ----------------------------------------------------------------------------
module image_loader
   import image_loader_pkg::*;
#(
   parameter int unsigned IMG_ROWS    = IMG_ROWS_DEF,
   parameter int unsigned IMG_COLS    = IMG_COLS_DEF,
   parameter int unsigned PIX_W       = PIX_W_DEF,
   parameter int unsigned ROW_AW      = ROW_AW_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      rxValid,
   input  logic [PIX_W-1:0]          rxData,
   output logic                      ramWe,
   output logic [ROW_AW-1:0]         ramAddr,
   output logic [IMG_COLS*PIX_W-1:0] ramData,
   output logic                      busy,
   output logic                      frameReady,
   output logic                      loadError,
   output logic [CHK_W-1:0]          checksum
);

   localparam logic [ROW_AW-1:0] ROW_LAST  = ROW_AW'(IMG_ROWS - 1);
   localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYC - 1);

   load_state_t       state;
   logic [ROW_AW-1:0] row;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              accept;
   logic              restart;
   logic              last_col;

   // start wins over a same-cycle byte; FLUSH defers start until DONE.
   always_comb begin
      accept  = (state == ST_LOAD) && rxValid && !start;
      restart = start && (state != ST_FLUSH);
   end

   image_loader_row_packer #(
      .IMG_COLS (IMG_COLS),
      .PIX_W    (PIX_W)
   ) u_packer (
      .clock    (clock),
      .reset    (reset),
      .clear    (restart),
      .shift_en (accept),
      .rx_data  (rxData),
      .last_col (last_col),
      .row_we   (ramWe),
      .row_data (ramData)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         row        <= '0;
         tmo_cnt    <= '0;
         checksum   <= '0;
         ramAddr    <= '0;
         busy       <= 1'b0;
         frameReady <= 1'b0;
         loadError  <= 1'b0;
      end else if (restart) begin
         state      <= ST_LOAD;
         row        <= '0;
         tmo_cnt    <= '0;
         checksum   <= '0;
         busy       <= 1'b1;
         frameReady <= 1'b0;
         loadError  <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  checksum <= checksum + CHK_W'(rxData);
                  tmo_cnt  <= '0;
                  if (last_col) begin
                     // ramAddr lands on the same edge as the packer's ramWe.
                     ramAddr <= row;
                     if (row == ROW_LAST) begin
                        state <= ST_FLUSH;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end
               end else if (tmo_cnt >= TMO_LIMIT) begin
                  state     <= ST_ERROR;
                  busy      <= 1'b0;
                  loadError <= 1'b1;
               end else if (tmo_cnt != '1) begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_FLUSH: begin
               state      <= ST_DONE;
               busy       <= 1'b0;
               frameReady <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// ----------------------------------------------------------------------------
// tb_image_loader
//   Directed bench for image_loader on a reduced 6x4 frame with a 40-cycle
//   timeout. A small RAM model records every ramWe write; expected row words
//   and checksums are computed from the byte sequences sent.
// ----------------------------------------------------------------------------
module tb_image_loader;

   localparam int unsigned ROWS = 6;
   localparam int unsigned COLS = 4;
   localparam int unsigned PW   = 8;
   localparam int unsigned AW   = 3;
   localparam int unsigned TMO  = 40;
   localparam int unsigned RW   = COLS * PW;
   localparam int          NBYTES = ROWS * COLS;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic          rxValid;
   logic [PW-1:0] rxData;
   logic          ramWe;
   logic [AW-1:0] ramAddr;
   logic [RW-1:0] ramData;
   logic          busy;
   logic          frameReady;
   logic          loadError;
   logic [15:0]   checksum;

   int checks = 0;
   int errors = 0;
   int busy_low;
   int we0;

   int            we_count = 0;
   logic [AW-1:0] last_addr;
   logic [RW-1:0] mem [ROWS];

   image_loader #(
      .IMG_ROWS    (ROWS),
      .IMG_COLS    (COLS),
      .PIX_W       (PW),
      .ROW_AW      (AW),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .rxValid    (rxValid),
      .rxData     (rxData),
      .ramWe      (ramWe),
      .ramAddr    (ramAddr),
      .ramData    (ramData),
      .busy       (busy),
      .frameReady (frameReady),
      .loadError  (loadError),
      .checksum   (checksum)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (ramWe) begin
         mem[ramAddr] <= ramData;
         last_addr    <= ramAddr;
         we_count     <= we_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] row_word(input int base, input int r);
      logic [RW-1:0] w;
      w = '0;
      for (int c = 0; c < int'(COLS); c++) begin
         w[c*PW +: PW] = 8'(base + r * int'(COLS) + c);
      end
      return w;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [PW-1:0] b);
      rxData  = b;
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
   endtask

   task automatic send_frame(input int base, input int gap, input int long_at, input int long_gap);
      for (int i = 0; i < NBYTES; i++) begin
         send_byte(8'(base + i));
         if (!busy) busy_low++;
         if (i != NBYTES - 1) begin
            for (int g = 0; g < gap + ((i == long_at) ? long_gap : 0); g++) begin
               tick();
               if (!busy) busy_low++;
            end
         end
      end
   endtask

   task automatic check_frame(input string tag, input int base);
      for (int r = 0; r < int'(ROWS); r++) begin
         chk($sformatf("%s_row%0d", tag, r), mem[r], row_word(base, r));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      rxValid = 1'b0;
      rxData  = '0;
      tick();
      tick();
      chk("rst_we",    ramWe,      1'b0);
      chk("rst_addr",  ramAddr,    '0);
      chk("rst_data",  ramData,    '0);
      chk("rst_busy",  busy,       1'b0);
      chk("rst_ready", frameReady, 1'b0);
      chk("rst_err",   loadError,  1'b0);
      chk("rst_sum",   checksum,   16'h0000);

      reset = 1'b1;
      tick();

      // IDLE ignores bytes, and also the byte coincident with start.
      send_byte(8'h55);
      chk("idle_sum",  checksum, 16'h0000);
      chk("idle_busy", busy,     1'b0);
      start = 1'b1; rxValid = 1'b1; rxData = 8'h77;
      tick();
      start = 1'b0; rxValid = 1'b0;
      chk("start_busy", busy,     1'b1);
      chk("start_sum",  checksum, 16'h0000);

      // Frame 1: back-to-back bytes 0..23.
      we0 = we_count; busy_low = 0;
      send_frame(0, 0, -1, 0);
      chk("f1_flush_we",    ramWe,      1'b1);
      chk("f1_flush_addr",  ramAddr,    3'd5);
      chk("f1_flush_data",  ramData,    row_word(0, 5));
      chk("f1_flush_ready", frameReady, 1'b0);
      chk("f1_flush_busy",  busy,       1'b1);
      chk("f1_sum",         checksum,   16'h0114);
      chk("f1_busy_low",    busy_low,   0);
      // start during FLUSH is deferred to DONE.
      start = 1'b1;
      tick();
      chk("f1_ready",      frameReady,      1'b1);
      chk("f1_done_busy",  busy,            1'b0);
      chk("f1_done_we",    ramWe,           1'b0);
      chk("f1_writes",     we_count - we0,  6);
      chk("f1_last_addr",  last_addr,       3'd5);
      check_frame("f1", 0);
      tick();
      start = 1'b0;
      chk("restart_ready", frameReady, 1'b0);
      chk("restart_busy",  busy,       1'b1);
      chk("restart_sum",   checksum,   16'h0000);

      // Frame 2: 3-cycle gaps plus 35 extra idle cycles mid-row 2.
      we0 = we_count; busy_low = 0;
      send_frame(50, 3, 2 * int'(COLS) + 1, 35);
      chk("f2_flush_we",   ramWe,   1'b1);
      chk("f2_flush_addr", ramAddr, 3'd5);
      send_byte(8'hAA);
      chk("f2_ready",    frameReady,     1'b1);
      chk("f2_err",      loadError,      1'b0);
      chk("f2_sum",      checksum,       16'h05C4);
      chk("f2_busy_low", busy_low,       0);
      chk("f2_writes",   we_count - we0, 6);
      check_frame("f2", 50);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("done_sum",    checksum,       16'h05C4);
      chk("done_writes", we_count - we0, 6);
      chk("done_ready",  frameReady,     1'b1);

      // Timeout: stall in row 2 after two full rows.
      start = 1'b1; tick(); start = 1'b0;
      we0 = we_count;
      for (int i = 0; i < 2 * int'(COLS) + 2; i++) send_byte(8'(i));
      chk("to_writes",    we_count - we0, 2);
      chk("to_last_addr", last_addr,      3'd1);
      chk("to_sum",       checksum,       16'h002D);
      repeat (TMO - 2) tick();
      chk("to_early_err",  loadError, 1'b0);
      chk("to_early_busy", busy,      1'b1);
      repeat (4) tick();
      chk("to_err",        loadError,      1'b1);
      chk("to_busy",       busy,           1'b0);
      chk("to_no_write",   we_count - we0, 2);
      send_byte(8'h33);
      chk("to_err_sum",    checksum,       16'h002D);
      start = 1'b1; tick(); start = 1'b0;
      chk("to_restart_busy", busy,      1'b1);
      chk("to_restart_err",  loadError, 1'b0);
      chk("to_restart_sum",  checksum,  16'h0000);

      // start in LOAD with a coincident byte drops that byte.
      we0 = we_count;
      for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
      chk("rs_writes",    we_count - we0, 1);
      chk("rs_last_addr", last_addr,      3'd0);
      chk("rs_sum",       checksum,       16'h03CA);
      start = 1'b1; rxValid = 1'b1; rxData = 8'hEE;
      tick();
      start = 1'b0; rxValid = 1'b0;
      chk("rs_sum_clr", checksum, 16'h0000);
      send_frame(100, 0, -1, 0);
      tick();
      chk("rs_ready", frameReady, 1'b1);
      chk("rs_sum2",  checksum,   16'h0A74);
      chk("rs_row0",  mem[0],     32'h67666564);
      check_frame("f3", 100);

      // Asynchronous reset in the middle of a cycle during row 2.
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 2 * int'(COLS) + 2; i++) send_byte(8'(8'h10 + i));
      chk("ar_pre_addr", ramAddr, 3'd1);
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      chk("ar_we",    ramWe,      1'b0);
      chk("ar_addr",  ramAddr,    '0);
      chk("ar_data",  ramData,    '0);
      chk("ar_busy",  busy,       1'b0);
      chk("ar_ready", frameReady, 1'b0);
      chk("ar_err",   loadError,  1'b0);
      chk("ar_sum",   checksum,   16'h0000);
      @(posedge clock);
      #1;
      reset = 1'b1;
      we0 = we_count;
      for (int i = 0; i < int'(COLS) + 2; i++) send_byte(8'(8'h80 + i));
      chk("ar_idle_sum",    checksum,       16'h0000);
      chk("ar_idle_busy",   busy,           1'b0);
      chk("ar_idle_writes", we_count - we0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
